// File: rtl/dcache_arb.sv
// Data-cache request arbiter between the LSQ and an auxiliary requester, with flush-orphan load dropping.
// Optional starvation override for aux enabled by defining DCACHE_ARB_STARVE_EN (otherwise strict LSQ priority).
module dcache_arb #(
    parameter int STARVE_LIMIT  = 8,
    parameter int AUX_MAX_OUTST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsq_dc_req,
    input  logic [3:0]  lsq_dc_op,
    input  logic [31:0] lsq_dc_addr,
    input  logic [3:0]  lsq_dc_lsqid,
    input  logic [31:0] lsq_dc_wdata,
    input  logic        lsq_dc_flush,
    output logic        dcache_ready,
    output logic        dcache_valid,
    output logic        dcache_error,
    output logic [3:0]  dcache_lsqid,
    output logic [31:0] dcache_rdata,
    input  logic        aux_req,
    input  logic [3:0]  aux_op,
    input  logic [31:0] aux_addr,
    input  logic [31:0] aux_wdata,
    input  logic [3:0]  aux_id,
    output logic        aux_ready,
    output logic        aux_valid,
    output logic        aux_error,
    output logic [3:0]  aux_rid,
    output logic [31:0] aux_rdata,
    output logic        arb_dc_req,
    output logic [3:0]  arb_dc_op,
    output logic [31:0] arb_dc_addr,
    output logic [31:0] arb_dc_wdata,
    output logic [4:0]  arb_dc_tag,
    output logic        arb_dc_flush,
    input  logic        dc_ready,
    input  logic        dc_valid,
    input  logic        dc_error,
    input  logic [4:0]  dc_tag,
    input  logic [31:0] dc_rdata
);

    localparam int OUTST_W = $clog2(AUX_MAX_OUTST + 1);

    logic [15:0]        r_pending;
    logic [15:0]        r_stale;
    logic [OUTST_W-1:0] r_aux_outst;

    logic        w_lsq_load;
    logic        w_lsq_elig;
    logic        w_aux_elig;
    logic        w_starve_prio;
    logic        w_grant_lsq;
    logic        w_grant_aux;
    logic        w_lsq_beat;
    logic        w_aux_beat;
    logic        w_resp_lsq;
    logic        w_resp_aux;
    logic        w_lsq_fwd;
    logic [15:0] w_resp_mask;
    logic [15:0] w_beat_mask;

    // A load may not issue while its index is stale or during a flush; stores keep draining.
    assign w_lsq_load = ~lsq_dc_op[0];
    assign w_lsq_elig = lsq_dc_req & ~(w_lsq_load & (r_stale[lsq_dc_lsqid] | lsq_dc_flush));
    assign w_aux_elig = aux_req & ((r_aux_outst < OUTST_W'(AUX_MAX_OUTST)) | aux_op[0]);

`ifdef DCACHE_ARB_STARVE_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] r_starve_cnt;

    assign w_starve_prio = (r_starve_cnt == STARVE_W'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_aux_beat || !aux_req) begin
            r_starve_cnt <= '0;
        end else if (w_aux_elig && !w_starve_prio) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    // Strict priority: the override never fires (a negative limit is never configured).
    assign w_starve_prio = (STARVE_LIMIT < 0);
`endif

    assign w_grant_aux = w_aux_elig & (~w_lsq_elig | w_starve_prio);
    assign w_grant_lsq = w_lsq_elig & ~w_grant_aux;
    assign w_lsq_beat  = w_grant_lsq & dc_ready;
    assign w_aux_beat  = w_grant_aux & dc_ready;

    assign dcache_ready = w_lsq_beat;
    assign aux_ready    = w_aux_beat;
    assign arb_dc_req   = w_grant_lsq | w_grant_aux;
    assign arb_dc_flush = lsq_dc_flush;

    always_comb begin
        arb_dc_op    = 4'h0;
        arb_dc_addr  = 32'h0;
        arb_dc_wdata = 32'h0;
        arb_dc_tag   = 5'h0;
        if (w_grant_aux) begin
            arb_dc_op    = aux_op;
            arb_dc_addr  = aux_addr;
            arb_dc_wdata = aux_wdata;
            arb_dc_tag   = {1'b1, aux_id};
        end else if (w_grant_lsq) begin
            arb_dc_op    = lsq_dc_op;
            arb_dc_addr  = lsq_dc_addr;
            arb_dc_wdata = lsq_dc_wdata;
            arb_dc_tag   = {1'b0, lsq_dc_lsqid};
        end
    end

    assign w_resp_lsq  = dc_valid & ~dc_tag[4];
    assign w_resp_aux  = dc_valid & dc_tag[4];
    assign w_resp_mask = w_resp_lsq ? (16'h1 << dc_tag[3:0]) : 16'h0;
    assign w_beat_mask = (w_lsq_beat & w_lsq_load) ? (16'h1 << lsq_dc_lsqid) : 16'h0;
    assign w_lsq_fwd   = w_resp_lsq & ~r_stale[dc_tag[3:0]];

    assign dcache_valid = w_lsq_fwd;
    assign dcache_error = w_lsq_fwd & dc_error;
    assign dcache_lsqid = w_lsq_fwd ? dc_tag[3:0] : 4'h0;
    assign dcache_rdata = w_lsq_fwd ? dc_rdata : 32'h0;

    assign aux_valid = w_resp_aux;
    assign aux_error = w_resp_aux & dc_error;
    assign aux_rid   = w_resp_aux ? dc_tag[3:0] : 4'h0;
    assign aux_rdata = w_resp_aux ? dc_rdata : 32'h0;

    // A response landing in the flush cycle retires its index, so it is not marked stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= '0;
            r_stale     <= '0;
            r_aux_outst <= '0;
        end else begin
            r_pending <= (r_pending & ~w_resp_mask) | w_beat_mask;
            r_stale   <= (r_stale & ~w_resp_mask)
                       | (lsq_dc_flush ? (r_pending & ~w_resp_mask) : 16'h0);
            case ({w_aux_beat & ~aux_op[0], w_resp_aux})
                2'b10:   r_aux_outst <= r_aux_outst + 1'b1;
                2'b01:   r_aux_outst <= r_aux_outst - 1'b1;
                default: r_aux_outst <= r_aux_outst;
            endcase
        end
    end

endmodule
